mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one unified `mem` instance between the instruction-fetch port (IF) and the data-memory port (MEM) of `processor`.
- Each cycle it selects one requester and forwards its command, address and data to memory.
- It returns the memory's accept response to that requester only.
- It keeps a per-tag ownership table so that each load's returned data/tag goes back to the requester that issued it.
- It sits between `processor` and a single `mem`, replacing the separate IM/DM instances.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive D grants while I is pending before I is forced a grant (range 1..15).
- NUM_TAGS, 16: tag space of `mem`; tag 0 means "no tag", so usable tags are 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- proc2Imem_addr  input  32  fetch address
- proc2Imem_command  input  2  BUS_NONE / BUS_LOAD (BUS_STORE from I is treated as BUS_NONE)
- Imem2proc_response  output  4  accept tag for I; 0 = not accepted
- Imem2proc_data  output  32  returned data for I
- Imem2proc_tag  output  4  completion tag for I; 0 = none
- proc2Dmem_addr  input  32  data address
- proc2Dmem_data  input  32  store data
- proc2Dmem_command  input  2  BUS_NONE / BUS_LOAD / BUS_STORE
- Dmem2proc_response  output  4  accept tag for D
- Dmem2proc_data  output  32  returned data for D
- Dmem2proc_tag  output  4  completion tag for D
- proc2mem_addr  output  32  to mem
- proc2mem_data  output  32  to mem
- proc2mem_command  output  2  to mem
- mem2proc_response  input  4  from mem
- mem2proc_data  input  32  from mem
- mem2proc_tag  input  4  from mem
- outstanding_cnt  output  5  number of valid table entries
- tag_err  output  1  sticky; an unowned tag returned

Behaviour:
- Encodings: BUS_NONE=2'h0, BUS_LOAD=2'h1, BUS_STORE=2'h2.
- Grant (combinational, same cycle):
  - D pending and I idle → grant D.
  - I pending and D idle → grant I.
  - Both pending → grant D, unless d_streak == STARVE_LIMIT, in which case grant I.
- d_streak (4-bit register):
  - Increments on a cycle where D is granted while I is pending.
  - Clears to 0 on any I grant, or on any cycle I is not pending.
  - Saturates at STARVE_LIMIT.
- Forwarding:
  - proc2mem_* carries the granted requester's addr/data/command.
  - proc2mem_data = 0 on an I grant.
  - No grant → command BUS_NONE, addr 0, data 0.
- Response:
  - The granted side's *2proc_response = mem2proc_response.
  - The non-granted side sees 0, which it must treat as a stall and retry next cycle.
- Ownership table: NUM_TAGS entries of {valid, owner}, owner 0 = I, 1 = D.
  - Allocate: granted command is BUS_LOAD and mem2proc_response != 0 → at the clock edge, entry[response] := {1, granted side}.
  - Stores are never recorded.
- Completion (combinational routing from current table state):
  - Condition: mem2proc_tag != 0 and entry[mem2proc_tag].valid.
  - The owner's *2proc_tag = mem2proc_tag and *2proc_data = mem2proc_data.
  - The other side's tag = 0 and data = 0.
  - At the edge the entry is cleared.
- Unowned return: mem2proc_tag != 0 with an invalid entry → both tags 0, data dropped, tag_err := 1 (sticky until rst).
- Same tag retired and re-allocated in one cycle: clear first, then allocate. The entry ends valid with the new owner.
- Re-allocation of a still-valid tag (memory fault):
  - The entry is overwritten with the new owner.
  - tag_err := 1.
  - outstanding_cnt is unchanged.
- outstanding_cnt: +1 per allocation, −1 per valid completion; same cycle → net 0. Range 0..15.
- Reset (synchronous, also mid-operation), at the next clk edge:
  - All table entries invalid.
  - d_streak = 0, outstanding_cnt = 0, tag_err = 0.
  - Combinational outputs follow their rules.
  - In-flight tags are forgotten; their later returns set tag_err.
- Latency: grant/response 0 cycles (combinational pass-through); completion routing 0 cycles; table updates visible the next cycle.

Test Plan:
- I-only BUS_LOAD addr 0x40, mem response 3 → Imem2proc_response=3, Dmem2proc_response=0, outstanding_cnt=1. Later mem tag 3 with data 0xDEADBEEF → Imem2proc_tag=3, Imem2proc_data=0xDEADBEEF, Dmem2proc_tag=0, outstanding_cnt=0.
- I and D both BUS_LOAD in the same cycle → proc2mem_addr = D addr, Imem2proc_response=0. Next cycle D = BUS_NONE → I granted, d_streak=0.
- D BUS_LOAD and I BUS_LOAD held for 6 cycles, STARVE_LIMIT=4 → grants D,D,D,D,I,D.
- I allocated tag 2, D allocated tag 5; mem returns tag 5 then tag 2 → Dmem2proc_tag=5, then Imem2proc_tag=2; tag_err=0.
- D BUS_STORE accepted with response 7, outstanding_cnt unchanged. Then mem2proc_tag=7 → both tags 0, tag_err=1 and it stays 1.
- Two loads outstanding, rst pulsed for 1 cycle → outstanding_cnt=0, tag_err=0. Old tag return afterwards → dropped, tag_err=1.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory between the instruction-fetch (I)
// and data (D) ports of the processor. It grants one requester per cycle,
// forwards that requester's command, and returns the memory's accept tag to
// it. A per-tag ownership table routes each load completion back to the
// requester that issued the load.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned NUM_TAGS     = 16
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] proc2Imem_addr,
  input  logic [1:0]  proc2Imem_command,
  output logic [3:0]  Imem2proc_response,
  output logic [31:0] Imem2proc_data,
  output logic [3:0]  Imem2proc_tag,

  input  logic [31:0] proc2Dmem_addr,
  input  logic [31:0] proc2Dmem_data,
  input  logic [1:0]  proc2Dmem_command,
  output logic [3:0]  Dmem2proc_response,
  output logic [31:0] Dmem2proc_data,
  output logic [3:0]  Dmem2proc_tag,

  output logic [31:0] proc2mem_addr,
  output logic [31:0] proc2mem_data,
  output logic [1:0]  proc2mem_command,
  input  logic [3:0]  mem2proc_response,
  input  logic [31:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,

  output logic [4:0]  outstanding_cnt,
  output logic        tag_err
);

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

  // Ownership table: one valid bit and one owner bit (0 = I, 1 = D) per tag
  logic [NUM_TAGS-1:0] r_valid;
  logic [NUM_TAGS-1:0] r_owner;
  logic [3:0]          r_d_streak;
  logic [4:0]          r_cnt;
  logic                r_tag_err;

  logic w_i_pend;
  logic w_d_pend;
  logic w_grant_i;
  logic w_grant_d;
  logic w_alloc;
  logic w_tag_live;
  logic w_cmp;
  logic w_unowned;
  logic w_same_tag;
  logic w_realloc_fault;
  logic w_cnt_inc;

  // Request decode and grant: D wins ties unless I has been starved too long
  always_comb begin
    w_i_pend  = (proc2Imem_command == BUS_LOAD);
    w_d_pend  = (proc2Dmem_command == BUS_LOAD) || (proc2Dmem_command == BUS_STORE);
    w_grant_i = w_i_pend && (!w_d_pend || (r_d_streak == STREAK_MAX));
    w_grant_d = w_d_pend && !w_grant_i;
  end

  // Forward the granted request to memory and steer the accept response
  always_comb begin
    proc2mem_addr      = '0;
    proc2mem_data      = '0;
    proc2mem_command   = BUS_NONE;
    Imem2proc_response = '0;
    Dmem2proc_response = '0;
    if (w_grant_i) begin
      proc2mem_addr      = proc2Imem_addr;
      proc2mem_command   = BUS_LOAD;
      Imem2proc_response = mem2proc_response;
    end else if (w_grant_d) begin
      proc2mem_addr      = proc2Dmem_addr;
      proc2mem_data      = proc2Dmem_data;
      proc2mem_command   = proc2Dmem_command;
      Dmem2proc_response = mem2proc_response;
    end
  end

  // Classify this cycle's table activity (allocation, completion, faults)
  always_comb begin
    w_alloc    = (proc2mem_command == BUS_LOAD) && (mem2proc_response != 4'd0);
    w_tag_live = r_valid[mem2proc_tag];
    w_cmp      = (mem2proc_tag != 4'd0) && w_tag_live;
    w_unowned  = (mem2proc_tag != 4'd0) && !w_tag_live;
    w_same_tag = w_cmp && (mem2proc_tag == mem2proc_response);
    // A tag retiring this cycle is free for re-allocation; any other live tag is a fault
    w_realloc_fault = w_alloc && r_valid[mem2proc_response] && !w_same_tag;
    w_cnt_inc       = w_alloc && !w_realloc_fault;
  end

  // Route a completion to the owner recorded in the table
  always_comb begin
    Imem2proc_tag  = '0;
    Imem2proc_data = '0;
    Dmem2proc_tag  = '0;
    Dmem2proc_data = '0;
    if (w_cmp) begin
      if (r_owner[mem2proc_tag]) begin
        Dmem2proc_tag  = mem2proc_tag;
        Dmem2proc_data = mem2proc_data;
      end else begin
        Imem2proc_tag  = mem2proc_tag;
        Imem2proc_data = mem2proc_data;
      end
    end
  end

  // D-streak counter tracking consecutive D grants while I waits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_streak <= '0;
    end else if (w_grant_d && w_i_pend) begin
      if (r_d_streak != STREAK_MAX)
        r_d_streak <= r_d_streak + 4'd1;
    end else begin
      r_d_streak <= '0;
    end
  end

  // Table update: clear the retiring entry first, then allocate so a reused tag ends valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_owner <= '0;
    end else begin
      if (w_cmp)
        r_valid[mem2proc_tag] <= 1'b0;
      if (w_alloc) begin
        r_valid[mem2proc_response] <= 1'b1;
        r_owner[mem2proc_response] <= w_grant_d;
      end
    end
  end

  // Outstanding-load counter and sticky tag error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_tag_err <= 1'b0;
    end else begin
      case ({w_cnt_inc, w_cmp})
        2'b10:   r_cnt <= r_cnt + 5'd1;
        2'b01:   r_cnt <= r_cnt - 5'd1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_unowned || w_realloc_fault)
        r_tag_err <= 1'b1;
    end
  end

  assign outstanding_cnt = r_cnt;
  assign tag_err         = r_tag_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: the driver applies one directed vector per
// cycle and queues its hand-computed expectation; the monitor pops and
// compares at the falling edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr;
  logic [1:0]  i_cmd;
  logic [3:0]  i_resp;
  logic [31:0] i_data;
  logic [3:0]  i_tag;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_cmd;
  logic [3:0]  d_resp;
  logic [31:0] d_data;
  logic [3:0]  d_tag;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [1:0]  m_cmd;
  logic [3:0]  m_resp;
  logic [31:0] m_rdata;
  logic [3:0]  m_tag;
  logic [4:0]  cnt;
  logic        err;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4), .NUM_TAGS(16)) dut (
    .clk(clk), .rst(rst),
    .proc2Imem_addr(i_addr), .proc2Imem_command(i_cmd),
    .Imem2proc_response(i_resp), .Imem2proc_data(i_data), .Imem2proc_tag(i_tag),
    .proc2Dmem_addr(d_addr), .proc2Dmem_data(d_wdata), .proc2Dmem_command(d_cmd),
    .Dmem2proc_response(d_resp), .Dmem2proc_data(d_data), .Dmem2proc_tag(d_tag),
    .proc2mem_addr(m_addr), .proc2mem_data(m_wdata), .proc2mem_command(m_cmd),
    .mem2proc_response(m_resp), .mem2proc_data(m_rdata), .mem2proc_tag(m_tag),
    .outstanding_cnt(cnt), .tag_err(err)
  );

  typedef struct packed {
    logic [31:0] maddr; logic [31:0] mdata; logic [1:0] mcmd;
    logic [3:0]  ir;    logic [3:0]  dr;
    logic [3:0]  it;    logic [31:0] id;
    logic [3:0]  dt;    logic [31:0] dd;
    logic [4:0]  cnt;   logic        err;
    int          vec;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vec_no  = 0;

  function automatic exp_t X(logic [31:0] maddr, logic [31:0] mdata, logic [1:0] mcmd,
                             logic [3:0] ir, logic [3:0] dr, logic [3:0] it, logic [31:0] id,
                             logic [3:0] dt, logic [31:0] dd, logic [4:0] c, logic e);
    exp_t r;
    r.maddr = maddr; r.mdata = mdata; r.mcmd = mcmd; r.ir = ir; r.dr = dr;
    r.it = it; r.id = id; r.dt = dt; r.dd = dd; r.cnt = c; r.err = e; r.vec = 0;
    return r;
  endfunction

  // Apply one cycle of stimulus and queue the expected response
  task automatic cyc(input logic r, input logic [1:0] ic, input logic [31:0] ia,
                     input logic [1:0] dc, input logic [31:0] da, input logic [31:0] dw,
                     input logic [3:0] mr, input logic [3:0] mt, input logic [31:0] md,
                     input exp_t e);
    @(posedge clk);
    #1;
    rst = r; i_cmd = ic; i_addr = ia; d_cmd = dc; d_addr = da; d_wdata = dw;
    m_resp = mr; m_tag = mt; m_rdata = md;
    e.vec = vec_no;
    vec_no++;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int v, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", v, name, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("proc2mem_addr", e.vec, m_addr, e.maddr);
        chk("proc2mem_data", e.vec, m_wdata, e.mdata);
        chk("proc2mem_command", e.vec, 32'(m_cmd), 32'(e.mcmd));
        chk("Imem2proc_response", e.vec, 32'(i_resp), 32'(e.ir));
        chk("Dmem2proc_response", e.vec, 32'(d_resp), 32'(e.dr));
        chk("Imem2proc_tag", e.vec, 32'(i_tag), 32'(e.it));
        chk("Imem2proc_data", e.vec, i_data, e.id);
        chk("Dmem2proc_tag", e.vec, 32'(d_tag), 32'(e.dt));
        chk("Dmem2proc_data", e.vec, d_data, e.dd);
        chk("outstanding_cnt", e.vec, 32'(cnt), 32'(e.cnt));
        chk("tag_err", e.vec, 32'(err), 32'(e.err));
      end
    end
  end

  localparam logic [1:0] N = 2'h0, L = 2'h1, S = 2'h2;

  initial begin
    rst = 1'b1; i_cmd = N; i_addr = '0; d_cmd = N; d_addr = '0; d_wdata = '0;
    m_resp = '0; m_tag = '0; m_rdata = '0;
    repeat (2) @(posedge clk);

    // Reset state
    cyc(0, N, 0, N, 0, 0, 0, 0, 0, X(0, 0, N, 0, 0, 0, 0, 0, 0, 0, 0));

    // I-only load, accepted as tag 3, then completion
    cyc(0, L, 32'h40, N, 0, 0, 3, 0, 0, X(32'h40, 0, L, 3, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, N, 0, N, 0, 0, 0, 0, 0, X(0, 0, N, 0, 0, 0, 0, 0, 0, 1, 0));
    cyc(0, N, 0, N, 0, 0, 0, 3, 32'hDEADBEEF,
        X(0, 0, N, 0, 0, 3, 32'hDEADBEEF, 0, 0, 1, 0));
    cyc(0, N, 0, N, 0, 0, 0, 0, 0, X(0, 0, N, 0, 0, 0, 0, 0, 0, 0, 0));

    // Both pending: D wins; D drops, I granted
    cyc(0, L, 32'h100, L, 32'h200, 0, 0, 0, 0, X(32'h200, 0, L, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, L, 32'h100, N, 0, 0, 0, 0, 0, X(32'h100, 0, L, 0, 0, 0, 0, 0, 0, 0, 0));

    // Starvation limit: D,D,D,D,I,D
    for (int k = 0; k < 6; k++)
      cyc(0, L, 32'h10, L, 32'h20, 0, 0, 0, 0,
          X((k == 4) ? 32'h10 : 32'h20, 0, L, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, N, 0, N, 0, 0, 0, 0, 0, X(0, 0, N, 0, 0, 0, 0, 0, 0, 0, 0));

    // I tag 2, D tag 5, returns out of order
    cyc(0, L, 32'h30, N, 0, 0, 2, 0, 0, X(32'h30, 0, L, 2, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, N, 0, L, 32'h50, 32'h99, 5, 0, 0, X(32'h50, 32'h99, L, 0, 5, 0, 0, 0, 0, 1, 0));
    cyc(0, N, 0, N, 0, 0, 0, 5, 32'hAAAA5555,
        X(0, 0, N, 0, 0, 0, 0, 5, 32'hAAAA5555, 2, 0));
    cyc(0, N, 0, N, 0, 0, 0, 2, 32'h12345678,
        X(0, 0, N, 0, 0, 2, 32'h12345678, 0, 0, 1, 0));
    cyc(0, N, 0, N, 0, 0, 0, 0, 0, X(0, 0, N, 0, 0, 0, 0, 0, 0, 0, 0));

    // Tag 9 retired to I and re-allocated to D in the same cycle
    cyc(0, L, 32'hA0, N, 0, 0, 9, 0, 0, X(32'hA0, 0, L, 9, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, N, 0, L, 32'hB0, 0, 9, 9, 32'h9999, X(32'hB0, 0, L, 0, 9, 9, 32'h9999, 0, 0, 1, 0));
    cyc(0, N, 0, N, 0, 0, 0, 0, 0, X(0, 0, N, 0, 0, 0, 0, 0, 0, 1, 0));
    cyc(0, N, 0, N, 0, 0, 0, 9, 32'h7777, X(0, 0, N, 0, 0, 0, 0, 9, 32'h7777, 1, 0));
    cyc(0, N, 0, N, 0, 0, 0, 0, 0, X(0, 0, N, 0, 0, 0, 0, 0, 0, 0, 0));

    // Store is not recorded; its tag returning is unowned
    cyc(0, N, 0, S, 32'h70, 32'hCAFE, 7, 0, 0, X(32'h70, 32'hCAFE, S, 0, 7, 0, 0, 0, 0, 0, 0));
    cyc(0, N, 0, N, 0, 0, 0, 0, 0, X(0, 0, N, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, N, 0, N, 0, 0, 0, 7, 32'h1111, X(0, 0, N, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, N, 0, N, 0, 0, 0, 0, 0, X(0, 0, N, 0, 0, 0, 0, 0, 0, 0, 1));
    cyc(0, N, 0, N, 0, 0, 0, 0, 0, X(0, 0, N, 0, 0, 0, 0, 0, 0, 0, 1));

    // Two loads outstanding, reset mid-operation, stale return afterwards
    cyc(0, L, 32'h80, N, 0, 0, 4, 0, 0, X(32'h80, 0, L, 4, 0, 0, 0, 0, 0, 0, 1));
    cyc(0, N, 0, L, 32'h90, 0, 6, 0, 0, X(32'h90, 0, L, 0, 6, 0, 0, 0, 0, 1, 1));
    cyc(1, N, 0, N, 0, 0, 0, 0, 0, X(0, 0, N, 0, 0, 0, 0, 0, 0, 2, 1));
    cyc(0, N, 0, N, 0, 0, 0, 0, 0, X(0, 0, N, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, N, 0, N, 0, 0, 0, 4, 32'h4444, X(0, 0, N, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, N, 0, N, 0, 0, 0, 0, 0, X(0, 0, N, 0, 0, 0, 0, 0, 0, 0, 1));

    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
